mem_arbiter: RTL and testbench

- Sequences the single-port 16-bit system memory in dut_soc between three requesters: core instruction fetch (read-only), core data access (read/write), and debug port (read/write).
- One transaction in flight at a time, fixed-latency memory, req/ack handshake per requester.
- Honours core halt by withholding fetch grants, so debug can inspect memory while the core is stopped.

---
 rtl/mem_arbiter_if.sv | 43 ++++
 rtl/mem_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Request, completion and memory-side signals of the three-requester memory arbiter.
// The arbiter connects through slave; requesters and the memory model use master.
interface mem_arbiter_if;
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;

    logic          halt;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_ack;
    logic          d_req;
    logic          d_wr;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ack;
    logic          dbg_req;
    logic          dbg_wr;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic          dbg_ack;
    logic [DW-1:0] rdata;
    logic          mem_en;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;
    logic [1:0]    grant_id;

    modport slave (
        input  halt, if_req, if_addr, d_req, d_wr, d_addr, d_wdata,
               dbg_req, dbg_wr, dbg_addr, dbg_wdata, mem_rdata,
        output if_ack, d_ack, dbg_ack, rdata, mem_en, mem_wr, mem_addr,
               mem_wdata, busy, grant_id
    );

    modport master (
        output halt, if_req, if_addr, d_req, d_wr, d_addr, d_wdata,
               dbg_req, dbg_wr, dbg_addr, dbg_wdata, mem_rdata,
        input  if_ack, d_ack, dbg_ack, rdata, mem_en, mem_wr, mem_addr,
               mem_wdata, busy, grant_id
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: debug, core data and core fetch share one fixed-latency
// memory, one transaction at a time, with fetch starvation relief and halt gating.
module mem_arbiter #(
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rstn,
    mem_arbiter_if.slave  bus
);
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;
    localparam int unsigned CW = 4;
    localparam int unsigned LW = 3;

    localparam logic [1:0] G_NONE = 2'd0;
    localparam logic [1:0] G_IF   = 2'd1;
    localparam logic [1:0] G_D    = 2'd2;
    localparam logic [1:0] G_DBG  = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t        state, state_nx;
    logic [1:0]    owner, owner_nx;
    logic          wr, wr_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [LW-1:0] wcnt, wcnt_nx;
    logic [AW-1:0] addr_nx;
    logic [DW-1:0] wdata_nx;
    logic [DW-1:0] rdata_nx;
    logic          fetch_ok;
    logic          starved;

    assign fetch_ok = bus.if_req && !bus.halt;
    assign starved  = (cnt == CW'(STARVE_MAX));

    // Next-state, arbitration and latched transaction fields
    always_comb begin
        state_nx = state;
        owner_nx = owner;
        wr_nx    = wr;
        cnt_nx   = cnt;
        wcnt_nx  = wcnt;
        addr_nx  = bus.mem_addr;
        wdata_nx = bus.mem_wdata;
        rdata_nx = bus.rdata;
        case (state)
            S_IDLE: begin
                if (!fetch_ok) cnt_nx = '0;
                if (bus.dbg_req) begin
                    owner_nx = G_DBG;
                    wr_nx    = bus.dbg_wr;
                    addr_nx  = bus.dbg_addr;
                    wdata_nx = bus.dbg_wdata;
                    state_nx = S_ISSUE;
                end else if (fetch_ok && starved) begin
                    owner_nx = G_IF;
                    wr_nx    = 1'b0;
                    addr_nx  = bus.if_addr;
                    cnt_nx   = '0;
                    state_nx = S_ISSUE;
                end else if (bus.d_req) begin
                    owner_nx = G_D;
                    wr_nx    = bus.d_wr;
                    addr_nx  = bus.d_addr;
                    wdata_nx = bus.d_wdata;
                    if (fetch_ok) cnt_nx = cnt + 1'b1;
                    state_nx = S_ISSUE;
                end else if (fetch_ok) begin
                    owner_nx = G_IF;
                    wr_nx    = 1'b0;
                    addr_nx  = bus.if_addr;
                    cnt_nx   = '0;
                    state_nx = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wcnt_nx  = LW'(MEM_LAT - 1);
                state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (wcnt == '0) begin
                    if (!wr) rdata_nx = bus.mem_rdata;
                    state_nx = S_RESP;
                end else begin
                    wcnt_nx = wcnt - 1'b1;
                end
            end
            S_RESP:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // State and registered outputs; outputs follow the state being entered
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= S_IDLE;
            owner         <= G_NONE;
            wr            <= 1'b0;
            cnt           <= '0;
            wcnt          <= '0;
            bus.mem_en    <= 1'b0;
            bus.mem_wr    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.rdata     <= '0;
            bus.busy      <= 1'b0;
            bus.grant_id  <= G_NONE;
            bus.if_ack    <= 1'b0;
            bus.d_ack     <= 1'b0;
            bus.dbg_ack   <= 1'b0;
        end else begin
            state         <= state_nx;
            owner         <= owner_nx;
            wr            <= wr_nx;
            cnt           <= cnt_nx;
            wcnt          <= wcnt_nx;
            bus.mem_en    <= (state_nx == S_ISSUE);
            bus.mem_wr    <= (state_nx == S_ISSUE) && wr_nx;
            bus.mem_addr  <= addr_nx;
            bus.mem_wdata <= wdata_nx;
            bus.rdata     <= rdata_nx;
            bus.busy      <= (state_nx != S_IDLE);
            bus.grant_id  <= (state_nx == S_IDLE) ? G_NONE : owner_nx;
            bus.if_ack    <= (state_nx == S_RESP) && (owner_nx == G_IF);
            bus.d_ack     <= (state_nx == S_RESP) && (owner_nx == G_D);
            bus.dbg_ack   <= (state_nx == S_RESP) && (owner_nx == G_DBG);
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: expected transactions queued at stimulus time and
// checked against the memory-side issue and the acknowledging requester.
module tb_mem_arbiter;
    localparam int unsigned MEM_LAT    = 1;
    localparam int unsigned STARVE_MAX = 2;
    localparam logic [1:0]  G_IF  = 2'd1;
    localparam logic [1:0]  G_D   = 2'd2;
    localparam logic [1:0]  G_DBG = 2'd3;

    typedef struct {
        logic [1:0]  id;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
    } txn_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    mem_arbiter_if bus ();

    mem_arbiter #(.MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: one-cycle read latency, data only driven in its valid cycle
    logic [15:0] mem [logic [15:0]];
    logic [15:0] rd_q = '0;
    logic        vld  = 1'b0;
    always begin
        @(posedge clk);
        if (bus.mem_en) begin
            rd_q <= mem.exists(bus.mem_addr) ? mem[bus.mem_addr] : (bus.mem_addr ^ 16'h5A5A);
            if (bus.mem_wr) mem[bus.mem_addr] = bus.mem_wdata;
        end
        vld <= bus.mem_en;
    end
    assign bus.mem_rdata = vld ? rd_q : 16'hDEAD;

    txn_t        sb [$];
    logic [15:0] shadow [logic [15:0]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] shadow_rd(input logic [15:0] a);
        return shadow.exists(a) ? shadow[a] : (a ^ 16'h5A5A);
    endfunction

    task automatic push(input logic [1:0] id, input logic wr, input logic [15:0] a,
                        input logic [15:0] wd);
        txn_t e;
        e.id    = id;
        e.wr    = wr;
        e.addr  = a;
        e.wdata = wd;
        e.rdata = wr ? 16'h0000 : shadow_rd(a);
        if (wr) shadow[a] = wd;
        sb.push_back(e);
    endtask

    function automatic logic [2:0] ack_mask(input logic [1:0] id);
        case (id)
            G_IF:    return 3'b001;
            G_D:     return 3'b010;
            G_DBG:   return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    // Monitor: issue order/content, grant hold, ack owner, latency and read data
    txn_t        cur;
    logic        pending = 1'b0;
    int          issue_cyc = 0;
    logic [15:0] last_rd = '0;
    logic [2:0]  acks;
    int          ifack_cnt = 0;
    int          dack_cnt  = 0;
    always begin
        @(negedge clk);
        if (!rstn) begin
            pending = 1'b0;
            last_rd = '0;
        end else begin
            chk("busy_vs_grant", 32'(bus.busy), 32'(bus.grant_id != 2'd0));
            if (bus.mem_en) begin
                chk("issue_expected", 32'(sb.size() != 0), 32'd1);
                chk("single_issue", 32'(pending), 32'd0);
                if (sb.size() != 0) begin
                    cur = sb.pop_front();
                    chk("issue_grant", 32'(bus.grant_id), 32'(cur.id));
                    chk("issue_addr", 32'(bus.mem_addr), 32'(cur.addr));
                    chk("issue_wr", 32'(bus.mem_wr), 32'(cur.wr));
                    if (cur.wr) chk("issue_wdata", 32'(bus.mem_wdata), 32'(cur.wdata));
                end
                pending   = 1'b1;
                issue_cyc = cyc;
            end
            if (pending) chk("grant_hold", 32'(bus.grant_id), 32'(cur.id));
            else         chk("grant_idle", 32'(bus.grant_id), 32'd0);
            acks = {bus.dbg_ack, bus.d_ack, bus.if_ack};
            if (bus.if_ack) ifack_cnt++;
            if (bus.d_ack)  dack_cnt++;
            if (acks != 3'b000) begin
                chk("ack_pending", 32'(pending), 32'd1);
                chk("ack_owner", 32'(acks), 32'(ack_mask(cur.id)));
                chk("ack_latency", 32'(cyc - issue_cyc), 32'(MEM_LAT + 1));
                if (cur.wr) begin
                    chk("ack_rdata_kept", 32'(bus.rdata), 32'(last_rd));
                end else begin
                    chk("ack_rdata", 32'(bus.rdata), 32'(cur.rdata));
                    last_rd = cur.rdata;
                end
                pending = 1'b0;
            end
        end
    end

    task automatic do_req(input logic [1:0] who, input logic wr, input logic [15:0] a,
                          input logic [15:0] wd, input string tag);
        logic got;
        got = 1'b0;
        case (who)
            G_IF:    begin bus.if_addr = a; bus.if_req = 1'b1; end
            G_D:     begin bus.d_wr = wr; bus.d_addr = a; bus.d_wdata = wd; bus.d_req = 1'b1; end
            default: begin bus.dbg_wr = wr; bus.dbg_addr = a; bus.dbg_wdata = wd; bus.dbg_req = 1'b1; end
        endcase
        for (int n = 0; n < 100; n++) begin
            @(posedge clk); #1;
            if ((who == G_IF && bus.if_ack) || (who == G_D && bus.d_ack) ||
                (who == G_DBG && bus.dbg_ack)) begin
                got = 1'b1;
                break;
            end
        end
        case (who)
            G_IF:    bus.if_req  = 1'b0;
            G_D:     bus.d_req   = 1'b0;
            default: bus.dbg_req = 1'b0;
        endcase
        chk(tag, 32'(got), 32'd1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"},   32'(bus.busy), 32'd0);
        chk({tag, "_grant"},  32'(bus.grant_id), 32'd0);
        chk({tag, "_mem_en"}, 32'(bus.mem_en), 32'd0);
        chk({tag, "_mem_wr"}, 32'(bus.mem_wr), 32'd0);
        chk({tag, "_acks"},   32'({bus.dbg_ack, bus.d_ack, bus.if_ack}), 32'd0);
        chk({tag, "_rdata"},  32'(bus.rdata), 32'd0);
        chk({tag, "_addr"},   32'(bus.mem_addr), 32'd0);
        chk({tag, "_wdata"},  32'(bus.mem_wdata), 32'd0);
    endtask

    logic seen, dbg_done, got_if;
    int   n_cyc, ifc0, dac0;

    initial begin
        bus.halt = 1'b0;  bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_req = 1'b0; bus.d_wr = 1'b0;   bus.d_addr = '0;   bus.d_wdata = '0;
        bus.dbg_req = 1'b0; bus.dbg_wr = 1'b0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
        mem[16'h0010]    = 16'hBEEF;
        shadow[16'h0010] = 16'hBEEF;

        repeat (3) @(posedge clk); #1;
        chk_zero("reset");
        rstn = 1'b1;
        @(posedge clk); #1;

        // Fetch read with cycle-exact checks
        push(G_IF, 1'b0, 16'h0010, 16'h0000);
        bus.if_addr = 16'h0010;
        bus.if_req  = 1'b1;
        @(posedge clk); #1;
        chk("t1_mem_en", 32'(bus.mem_en), 32'd1);
        chk("t1_mem_addr", 32'(bus.mem_addr), 32'h0010);
        chk("t1_mem_wr", 32'(bus.mem_wr), 32'd0);
        @(posedge clk); #1;
        chk("t1_no_early_ack", 32'(bus.if_ack), 32'd0);
        @(posedge clk); #1;
        chk("t1_if_ack", 32'(bus.if_ack), 32'd1);
        chk("t1_rdata", 32'(bus.rdata), 32'hBEEF);
        bus.if_req = 1'b0;
        @(posedge clk); #1;
        chk("t1_busy_low", 32'(bus.busy), 32'd0);
        chk("t1_ack_single", 32'(bus.if_ack), 32'd0);

        // Data write
        push(G_D, 1'b1, 16'h8000, 16'h1234);
        do_req(G_D, 1'b1, 16'h8000, 16'h1234, "t2_d_ack");
        chk("t2_rdata_kept", 32'(bus.rdata), 32'hBEEF);
        @(posedge clk); #1;

        // Simultaneous requests: debug, then data, then fetch
        push(G_DBG, 1'b1, 16'h0010, 16'hCAFE);
        push(G_D,   1'b0, 16'h0010, 16'h0000);
        push(G_IF,  1'b0, 16'h8000, 16'h0000);
        fork
            do_req(G_DBG, 1'b1, 16'h0010, 16'hCAFE, "t3_dbg_ack");
            do_req(G_D,   1'b0, 16'h0010, 16'h0000, "t3_d_ack");
            do_req(G_IF,  1'b0, 16'h8000, 16'h0000, "t3_if_ack");
        join
        repeat (2) @(posedge clk); #1;

        // Starvation relief with STARVE_MAX=2: D, D, F, D, D, F
        push(G_D,  1'b0, 16'h0500, 16'h0000);
        push(G_D,  1'b0, 16'h0501, 16'h0000);
        push(G_IF, 1'b0, 16'h0600, 16'h0000);
        push(G_D,  1'b0, 16'h0502, 16'h0000);
        push(G_D,  1'b0, 16'h0503, 16'h0000);
        push(G_IF, 1'b0, 16'h0601, 16'h0000);
        fork
            for (int i = 0; i < 4; i++) do_req(G_D, 1'b0, 16'h0500 + 16'(i), 16'h0000, "t4_d_ack");
            for (int j = 0; j < 2; j++) do_req(G_IF, 1'b0, 16'h0600 + 16'(j), 16'h0000, "t4_if_ack");
        join
        repeat (2) @(posedge clk); #1;

        // Halt withholds fetch while debug is still served
        ifc0 = ifack_cnt;
        bus.halt = 1'b1;
        push(G_DBG, 1'b0, 16'h0010, 16'h0000);
        push(G_IF,  1'b0, 16'h0300, 16'h0000);
        fork
            do_req(G_IF, 1'b0, 16'h0300, 16'h0000, "t5_if_ack");
            begin
                seen = 1'b0;
                dbg_done = 1'b0;
                for (int i = 0; i < 20; i++) begin
                    @(posedge clk); #1;
                    if (bus.grant_id == G_IF || bus.if_ack) seen = 1'b1;
                    if (bus.dbg_ack) begin
                        bus.dbg_req = 1'b0;
                        dbg_done = 1'b1;
                    end
                    if (i == 3) begin
                        bus.dbg_wr = 1'b0;
                        bus.dbg_addr = 16'h0010;
                        bus.dbg_req = 1'b1;
                    end
                end
                chk("t5_no_fetch_in_halt", 32'(seen), 32'd0);
                chk("t5_dbg_served", 32'(dbg_done), 32'd1);
                chk("t5_if_ack_count", 32'(ifack_cnt), 32'(ifc0));
                bus.halt = 1'b0;
                n_cyc = 0;
                got_if = 1'b0;
                for (int k = 0; k < 50; k++) begin
                    @(posedge clk); #1;
                    n_cyc++;
                    if (bus.if_ack) begin
                        got_if = 1'b1;
                        break;
                    end
                end
                chk("t5_resume_seen", 32'(got_if), 32'd1);
                chk("t5_resume_latency", 32'(n_cyc), 32'(MEM_LAT + 2));
            end
        join
        repeat (2) @(posedge clk); #1;

        // Reset during WAIT of a data read abandons it
        push(G_D, 1'b0, 16'h0200, 16'h0000);
        dac0 = dack_cnt;
        bus.d_wr = 1'b0;
        bus.d_addr = 16'h0200;
        bus.d_req = 1'b1;
        @(posedge clk); #1;
        chk("t6_issue", 32'(bus.mem_en), 32'd1);
        @(posedge clk); #1;
        chk("t6_in_wait", 32'(bus.busy), 32'd1);
        #1 rstn = 1'b0;
        #1 chk_zero("t6_async");
        bus.d_req = 1'b0;
        repeat (2) @(posedge clk); #1;
        rstn = 1'b1;
        repeat (3) @(posedge clk); #1;
        chk("t6_idle_busy", 32'(bus.busy), 32'd0);
        chk("t6_no_d_ack", 32'(dack_cnt), 32'(dac0));
        chk("t6_abandoned", 32'(sb.size()), 32'd0);
        push(G_D, 1'b0, 16'h0200, 16'h0000);
        do_req(G_D, 1'b0, 16'h0200, 16'h0000, "t6_retry_ack");
        repeat (3) @(posedge clk); #1;

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
